dma_tcdm_port_cut: RTL and testbench



---
 rtl/dma_tcdm_pkg.sv | 21 ++
 rtl/dma_tcdm_spill_fifo.sv | 49 ++++
 rtl/dma_tcdm_port_cut.sv | 130 +++++++++++++
 tb/tb_dma_tcdm_port_cut.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_tcdm_pkg.sv
// Shared types, widths and helpers for the DMA-to-TCDM port cut.
package dma_tcdm_pkg;

    localparam int unsigned TcdmAddrWidth = 32;
    localparam int unsigned TcdmDataWidth = 32;
    localparam int unsigned TcdmBeWidth   = TcdmDataWidth / 8;
    localparam int unsigned StallCntWidth = 32;

    typedef struct packed {
        logic [TcdmAddrWidth-1:0] add;
        logic                     wen;
        logic [TcdmDataWidth-1:0] wdata;
        logic [TcdmBeWidth-1:0]   be;
    } tcdm_req_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [StallCntWidth-1:0] sat_inc(input logic [StallCntWidth-1:0] val);
        return (&val) ? val : val + StallCntWidth'(1);
    endfunction

endpackage

// File: rtl/dma_tcdm_spill_fifo.sv
// Two-entry in-order spill buffer of TCDM requests; cuts the grant path.
module dma_tcdm_spill_fifo
    import dma_tcdm_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  tcdm_req_t data_i,
    input  logic      pop_i,
    output tcdm_req_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    tcdm_req_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= !wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= !rd_ptr_q;
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    // Payload storage needs no reset; occupancy gates its visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dma_tcdm_port_cut.sv
// Retiming/credit stage between a DMA bank port and a TCDM master port.
// Define DMA_TCDM_PORT_CUT_RSP_EN to register the upstream response path.
module dma_tcdm_port_cut
    import dma_tcdm_pkg::*;
#(
    parameter int unsigned AddrWidth      = TcdmAddrWidth,
    parameter int unsigned DataWidth      = TcdmDataWidth,
    parameter int unsigned BeWidth        = DataWidth / 8,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     up_req_i,
    output logic                     up_gnt_o,
    input  logic [AddrWidth-1:0]     up_add_i,
    input  logic                     up_wen_i,
    input  logic [DataWidth-1:0]     up_wdata_i,
    input  logic [BeWidth-1:0]       up_be_i,
    output logic                     up_r_valid_o,
    output logic [DataWidth-1:0]     up_r_rdata_o,
    output logic                     dn_req_o,
    input  logic                     dn_gnt_i,
    output logic [AddrWidth-1:0]     dn_add_o,
    output logic                     dn_wen_o,
    output logic [DataWidth-1:0]     dn_wdata_o,
    output logic [BeWidth-1:0]       dn_be_o,
    input  logic                     dn_r_valid_i,
    input  logic [DataWidth-1:0]     dn_r_rdata_i,
    input  logic                     stall_clr_i,
    output logic [StallCntWidth-1:0] stall_cnt_o,
    output logic                     err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    tcdm_req_t                push_data;
    tcdm_req_t                head;
    logic                     buf_full;
    logic                     buf_empty;
    logic                     up_hs;
    logic                     rsp_accept;
    logic                     rsp_dec;
    logic [CntWidth-1:0]      out_cnt_q;
    logic [StallCntWidth-1:0] stall_cnt_q;
    logic                     err_q;

    // Grant from registered state only; held low while reset discards state.
    assign up_gnt_o = !rst_i && !buf_full && (out_cnt_q < CntWidth'(MaxOutstanding));
    assign up_hs    = up_req_i && up_gnt_o;

    assign push_data = '{add:   TcdmAddrWidth'(up_add_i),
                         wen:   up_wen_i,
                         wdata: TcdmDataWidth'(up_wdata_i),
                         be:    TcdmBeWidth'(up_be_i)};

    dma_tcdm_spill_fifo u_spill (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (up_hs),
        .data_i  (push_data),
        .pop_i   (dn_gnt_i),
        .data_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign dn_req_o   = !buf_empty;
    assign dn_add_o   = AddrWidth'(head.add);
    assign dn_wen_o   = head.wen;
    assign dn_wdata_o = DataWidth'(head.wdata);
    assign dn_be_o    = BeWidth'(head.be);

`ifdef DMA_TCDM_PORT_CUT_RSP_EN
    logic                 rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;
    logic [CntWidth-1:0]  cnt_avail;

    // A captured response still owns one credit until it is delivered.
    assign cnt_avail  = out_cnt_q - CntWidth'(rsp_valid_q);
    assign rsp_accept = dn_r_valid_i && (cnt_avail != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_accept;
            if (dn_r_valid_i) rsp_rdata_q <= dn_r_rdata_i;
        end
    end

    assign up_r_valid_o = rsp_valid_q;
    assign up_r_rdata_o = rsp_rdata_q;
    assign rsp_dec      = rsp_valid_q;
`else
    assign rsp_accept   = dn_r_valid_i && (out_cnt_q != '0);
    assign up_r_valid_o = rsp_accept;
    assign up_r_rdata_o = dn_r_rdata_i;
    assign rsp_dec      = rsp_accept;
`endif

    // Credits: granted upstream but not yet answered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt_q <= '0;
        end else if (up_hs && !rsp_dec) begin
            out_cnt_q <= out_cnt_q + CntWidth'(1);
        end else if (rsp_dec && !up_hs) begin
            out_cnt_q <= out_cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (stall_clr_i) begin
                stall_cnt_q <= '0;
            end else if (dn_req_o && !dn_gnt_i) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (dn_r_valid_i && !rsp_accept) err_q <= 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dma_tcdm_port_cut.sv
// Directed vector bench for dma_tcdm_port_cut (combinational response build).
module tb_dma_tcdm_port_cut;
    import dma_tcdm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_req = 1'b0;
    logic        up_gnt_o;
    logic [31:0] up_add = '0;
    logic        up_wen = 1'b0;
    logic [31:0] up_wdata = '0;
    logic [3:0]  up_be = '0;
    logic        up_r_valid_o;
    logic [31:0] up_r_rdata_o;
    logic        dn_req_o;
    logic        dn_gnt = 1'b0;
    logic [31:0] dn_add_o;
    logic        dn_wen_o;
    logic [31:0] dn_wdata_o;
    logic [3:0]  dn_be_o;
    logic        dn_r_valid = 1'b0;
    logic [31:0] dn_r_rdata = '0;
    logic        stall_clr = 1'b0;
    logic [31:0] stall_cnt_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    dma_tcdm_port_cut #(
        .AddrWidth(32), .DataWidth(32), .BeWidth(4), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .up_req_i(up_req), .up_gnt_o(up_gnt_o), .up_add_i(up_add), .up_wen_i(up_wen),
        .up_wdata_i(up_wdata), .up_be_i(up_be),
        .up_r_valid_o(up_r_valid_o), .up_r_rdata_o(up_r_rdata_o),
        .dn_req_o(dn_req_o), .dn_gnt_i(dn_gnt), .dn_add_o(dn_add_o), .dn_wen_o(dn_wen_o),
        .dn_wdata_o(dn_wdata_o), .dn_be_o(dn_be_o),
        .dn_r_valid_i(dn_r_valid), .dn_r_rdata_i(dn_r_rdata),
        .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req;
        logic        wen;
        logic [31:0] add;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_gnt;
        logic        e_dn;
        logic [31:0] e_add;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int req, input int wen, input logic [31:0] add,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input int gnt, input int rv, input logic [31:0] rdata,
                                input int e_gnt, input int e_dn, input logic [31:0] e_add,
                                input int e_wen, input logic [31:0] e_wdata, input logic [3:0] e_be,
                                input int e_rv, input logic [31:0] e_rdata, input logic [31:0] e_stall);
        vec_t v;
        v.req = req[0];     v.wen = wen[0];     v.add = add;       v.wdata = wdata;  v.be = be;
        v.gnt = gnt[0];     v.rv = rv[0];       v.rdata = rdata;
        v.e_gnt = e_gnt[0]; v.e_dn = e_dn[0];   v.e_add = e_add;   v.e_wen = e_wen[0];
        v.e_wdata = e_wdata; v.e_be = e_be;     v.e_rv = e_rv[0];  v.e_rdata = e_rdata;
        v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        up_req = 1'b0; up_wen = 1'b0; up_add = '0; up_wdata = '0; up_be = '0;
        dn_r_valid = 1'b0; dn_r_rdata = '0; stall_clr = 1'b0;
    endtask

    int grants;

    initial begin
        // Single write, then response one cycle after grant.
        vecs.push_back(mk(1,0,32'h1000_0040,32'hCAFE_0001,4'hF, 1,0,32'h0, 1,0,32'h0,0,32'h0,4'h0, 0,32'h0, 32'd0));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,0,32'h0, 1,1,32'h1000_0040,0,32'hCAFE_0001,4'hF, 0,32'h0, 32'd0));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,1,32'h0, 1,0,32'h0,0,32'h0,4'h0, 1,32'h0, 32'd0));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,0,32'h0, 1,0,32'h0,0,32'h0,4'h0, 0,32'h0, 32'd0));
        // Eight back-to-back reads, TCDM latency of one cycle.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(int'(i < 8), 1, 32'(32'h2000_0000 + 4 * i), 32'h0, 4'hF,
                              1, int'(i >= 2), 32'(32'hD000_0000 + i - 2),
                              1, int'(i >= 1 && i <= 8), 32'(32'h2000_0000 + 4 * (i - 1)), 1, 32'h0, 4'hF,
                              int'(i >= 2), 32'(32'hD000_0000 + i - 2), 32'd0));
        end
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,0,32'h0, 1,0,32'h0,0,32'h0,4'h0, 0,32'h0, 32'd0));
        // Grant withheld for five cycles while requests stream.
        vecs.push_back(mk(1,0,32'h3000_0000,32'hBB00_0000,4'h1, 1,0,32'h0, 1,0,32'h0,0,32'h0,4'h0, 0,32'h0, 32'd0));
        vecs.push_back(mk(1,0,32'h3000_0004,32'hBB00_0001,4'h3, 0,0,32'h0, 1,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd0));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 0,0,32'h0, 0,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd1));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 0,0,32'h0, 0,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd2));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 0,0,32'h0, 0,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd3));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 0,0,32'h0, 0,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd4));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 1,0,32'h0, 0,1,32'h3000_0000,0,32'hBB00_0000,4'h1, 0,32'h0, 32'd5));
        vecs.push_back(mk(1,0,32'h3000_0008,32'hBB00_0002,4'hC, 1,1,32'hE000_0000, 1,1,32'h3000_0004,0,32'hBB00_0001,4'h3, 1,32'hE000_0000, 32'd5));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,1,32'hE000_0001, 1,1,32'h3000_0008,0,32'hBB00_0002,4'hC, 1,32'hE000_0001, 32'd5));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,1,32'hE000_0002, 1,0,32'h0,0,32'h0,4'h0, 1,32'hE000_0002, 32'd5));
        vecs.push_back(mk(0,0,32'h0,32'h0,4'h0, 1,0,32'h0, 1,0,32'h0,0,32'h0,4'h0, 0,32'h0, 32'd5));

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check1("in_reset up_gnt", up_gnt_o, 1'b0);
        check1("in_reset dn_req", dn_req_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("rst dn_req", dn_req_o, 1'b0);
        check1("rst up_r_valid", up_r_valid_o, 1'b0);
        check1("rst err", err_o, 1'b0);
        check32("rst stall_cnt", stall_cnt_o, 32'h0);
        check1("rst up_gnt", up_gnt_o, 1'b1);

        foreach (vecs[k]) begin
            @(negedge clk);
            up_req = vecs[k].req; up_wen = vecs[k].wen; up_add = vecs[k].add;
            up_wdata = vecs[k].wdata; up_be = vecs[k].be; dn_gnt = vecs[k].gnt;
            dn_r_valid = vecs[k].rv; dn_r_rdata = vecs[k].rdata;
            #1;
            check1($sformatf("v%0d up_gnt", k), up_gnt_o, vecs[k].e_gnt);
            check1($sformatf("v%0d dn_req", k), dn_req_o, vecs[k].e_dn);
            if (vecs[k].e_dn) begin
                check32($sformatf("v%0d dn_add", k), dn_add_o, vecs[k].e_add);
                check1($sformatf("v%0d dn_wen", k), dn_wen_o, vecs[k].e_wen);
                check32($sformatf("v%0d dn_wdata", k), dn_wdata_o, vecs[k].e_wdata);
                check32($sformatf("v%0d dn_be", k), 32'(dn_be_o), 32'(vecs[k].e_be));
            end
            check1($sformatf("v%0d up_r_valid", k), up_r_valid_o, vecs[k].e_rv);
            if (vecs[k].e_rv) check32($sformatf("v%0d up_r_rdata", k), up_r_rdata_o, vecs[k].e_rdata);
            check32($sformatf("v%0d stall_cnt", k), stall_cnt_o, vecs[k].e_stall);
        end
        @(negedge clk);
        idle_inputs();
        dn_gnt = 1'b1;

        // Credit limit: responses withheld.
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            up_req = 1'b1; up_wen = 1'b1; up_add = 32'(32'h5000_0000 + 4 * c); up_be = 4'hF;
            #1;
            if (up_gnt_o) grants++;
        end
        check32("credit grants", 32'(grants), 32'd4);
        @(negedge clk);
        dn_r_valid = 1'b1; dn_r_rdata = 32'h5555_0000;
        #1;
        check1("credit gnt at rsp", up_gnt_o, 1'b0);
        check1("credit rsp valid", up_r_valid_o, 1'b1);
        grants = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dn_r_valid = 1'b0;
            #1;
            if (up_gnt_o) grants++;
        end
        check32("credit extra grants", 32'(grants), 32'd1);
        up_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            up_req = 1'b0; dn_r_valid = 1'b1; dn_r_rdata = 32'(32'h5555_0001 + c);
            #1;
            check1($sformatf("drain%0d valid", c), up_r_valid_o, 1'b1);
        end

        // Spurious response with nothing outstanding.
        @(negedge clk);
        dn_r_valid = 1'b1; dn_r_rdata = 32'hBAD0_0000;
        #1;
        check1("spurious dropped", up_r_valid_o, 1'b0);
        check1("spurious err pre", err_o, 1'b0);
        @(negedge clk);
        dn_r_valid = 1'b0;
        #1;
        check1("spurious err set", err_o, 1'b1);

        // Reset with two requests buffered.
        @(negedge clk);
        dn_gnt = 1'b0; up_req = 1'b1; up_wen = 1'b0; up_add = 32'h6000_0000;
        @(negedge clk);
        up_add = 32'h6000_0004;
        #1;
        check1("prerst gnt occ1", up_gnt_o, 1'b1);
        @(negedge clk);
        up_req = 1'b0;
        #1;
        check1("prerst full gnt", up_gnt_o, 1'b0);
        check1("prerst dn_req", dn_req_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("postrst dn_req", dn_req_o, 1'b0);
        check1("postrst err", err_o, 1'b0);
        check32("postrst stall", stall_cnt_o, 32'h0);
        check1("postrst up_gnt", up_gnt_o, 1'b1);
        @(negedge clk);
        dn_r_valid = 1'b1;
        #1;
        check1("stray dropped", up_r_valid_o, 1'b0);
        @(negedge clk);
        dn_r_valid = 1'b0;
        #1;
        check1("stray err set", err_o, 1'b1);

        // Stall counter saturation and clear.
        @(negedge clk);
        up_req = 1'b1; up_wen = 1'b0; up_add = 32'h4000_0000; up_wdata = 32'h1234_5678; up_be = 4'hF;
        dn_gnt = 1'b0;
        @(negedge clk);
        up_req = 1'b0;
        #1;
        check1("sat dn_req", dn_req_o, 1'b1);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        @(negedge clk);
        #1;
        check32("sat step", stall_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        check32("sat hold", stall_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        stall_clr = 1'b1;
        @(negedge clk);
        stall_clr = 1'b0;
        #1;
        check32("clr priority", stall_cnt_o, 32'h0);
        @(negedge clk);
        #1;
        check32("count after clr", stall_cnt_o, 32'h1);
        @(negedge clk);
        dn_gnt = 1'b1;
        #1;
        check1("final dn_req", dn_req_o, 1'b1);
        check32("final dn_add", dn_add_o, 32'h4000_0000);
        @(negedge clk);
        dn_gnt = 1'b0; dn_r_valid = 1'b1; dn_r_rdata = 32'h0;
        #1;
        check1("final rsp valid", up_r_valid_o, 1'b1);
        check1("final err sticky", err_o, 1'b1);
        @(negedge clk);
        dn_r_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
